// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared types, constants and helpers for the posit decoder slice
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;

  // Signed regime value needs room for -(N-1)..N-2 plus a sign bit.
  function automatic int k_width(input int n);
    return $clog2(n) + 2;
  endfunction

  localparam int POSIT_KW = k_width(POSIT_N);

  // Not-a-Real: sign bit set, every other bit clear.
  localparam logic [POSIT_N-1:0] NAR_PATTERN = {1'b1, {(POSIT_N-1){1'b0}}};

  typedef struct packed {
    logic                       sign;
    logic signed [POSIT_KW-1:0] k;
    logic [POSIT_ES-1:0]        exp;
    logic [POSIT_N-1:0]         mant;
    logic                       zero;
    logic                       inf;
  } posit_dec_t;

endpackage

// File: rtl/posit_run_len.sv
// rtl/posit_run_len.sv - combinational length of the leading run of bits equal to the MSB
module posit_run_len #(
  parameter int W  = 31,
  parameter int MW = 6
) (
  input  logic [W-1:0]  i_bits,
  output logic [MW-1:0] o_m
);

  logic w_run;

  // Walk down from the MSB, counting until the first bit that differs from it.
  always_comb begin
    o_m   = '0;
    w_run = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_run && (i_bits[i] == i_bits[W-1])) begin
        o_m = o_m + MW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage posit field decoder; POSIT_DEC_STATS_EN adds special_cnt
module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic signed [RS+1:0] out_k,
  output logic [ES-1:0]        out_exp,
  output logic [N-1:0]         out_mant,
  output logic                 out_zero,
  output logic                 out_inf
`ifdef POSIT_DEC_STATS_EN
  ,
  output logic [15:0]          special_cnt
`endif
);

  logic                 w_adv1;
  logic                 w_adv2;

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic [N-2:0]         r_s1_abs;
  logic                 r_s1_zero;
  logic                 r_s1_inf;

  logic                 r_s2_valid;
  posit_dec_t           r_s2;

  logic [N-2:0]         w_bits;
  logic                 w_r0;
  logic [RS:0]          w_m;
  logic [RS+1:0]        w_m_ext;
  logic signed [RS+1:0] w_k;
  logic [N-2:0]         w_rem;
  logic [ES-1:0]        w_exp;
  logic [N-1:0]         w_mant;
  posit_dec_t           w_dec;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_adv2   = ~r_s2_valid | out_ready;
  assign w_adv1   = ~r_s1_valid | w_adv2;
  assign in_ready = w_adv1;

  // Stage 1: sign, magnitude and special-value flags. Only the low N-1 bits of
  // the magnitude matter, and those equal the negation of the low N-1 input bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_abs   <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_posit[N-1];
        r_s1_abs  <= in_posit[N-1] ? -in_posit[N-2:0] : in_posit[N-2:0];
        r_s1_zero <= (in_posit == '0);
        r_s1_inf  <= (in_posit == NAR_PATTERN);
      end
    end
  end

  assign w_bits = r_s1_abs;
  assign w_r0   = w_bits[N-2];

  posit_run_len #(
    .W  (N - 1),
    .MW (RS + 1)
  ) u_run_len (
    .i_bits (w_bits),
    .o_m    (w_m)
  );

  // A run of ones encodes k = m-1, a run of zeros encodes k = -m.
  assign w_m_ext = {1'b0, w_m};
  assign w_k     = w_r0 ? $signed(w_m_ext - 1'b1) : $signed(-w_m_ext);

  // Drop the run and its terminator; shifting past the end leaves zeros,
  // which supplies the implicit zero exponent/fraction bits of long regimes.
  assign w_rem  = w_bits << (32'(w_m) + 32'd1);
  assign w_exp  = w_rem[N-2 -: ES];
  assign w_mant = {1'b1, w_rem[N-2-ES:0], {ES{1'b0}}};

  // Assemble the decoded word; zero and NaR carry only their flag.
  always_comb begin
    w_dec      = '0;
    w_dec.zero = r_s1_zero;
    w_dec.inf  = r_s1_inf;
    if (!(r_s1_zero || r_s1_inf)) begin
      w_dec.sign = r_s1_sign;
      w_dec.k    = w_k;
      w_dec.exp  = w_exp;
      w_dec.mant = w_mant;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2 <= w_dec;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sign  = r_s2.sign;
  assign out_k     = r_s2.k;
  assign out_exp   = r_s2.exp;
  assign out_mant  = r_s2.mant;
  assign out_zero  = r_s2.zero;
  assign out_inf   = r_s2.inf;

`ifdef POSIT_DEC_STATS_EN
  logic [15:0] r_special_cnt;

  // Saturating count of zero/NaR results handed to the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_special_cnt <= '0;
    end else if (r_s2_valid && out_ready && (r_s2.zero || r_s2.inf) &&
                 (r_special_cnt != 16'hFFFF)) begin
      r_special_cnt <= r_special_cnt + 16'd1;
    end
  end

  assign special_cnt = r_special_cnt;
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - self-checking bench for posit_decode_pipe
module tb_posit_decode_pipe;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int RS = $clog2(N);
  localparam logic [N-1:0] NAR = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_posit;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic signed [RS+1:0] out_k;
  logic [ES-1:0]     out_exp;
  logic [N-1:0]      out_mant;
  logic              out_zero;
  logic              out_inf;
`ifdef POSIT_DEC_STATS_EN
  logic [15:0]       special_cnt;
`endif

  always #5 clk = ~clk;

  posit_decode_pipe #(.N(N), .ES(ES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_k     (out_k),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_inf   (out_inf)
`ifdef POSIT_DEC_STATS_EN
    ,
    .special_cnt (special_cnt)
`endif
  );

  typedef struct {
    bit           sign;
    int           k;
    int           exp;
    logic [N-1:0] mant;
    bit           zero;
    bit           inf;
  } dec_t;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int spec_model = 0;
  logic [N-1:0] sb [$];

  task automatic check(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Reference decode: read the bit string left to right as the posit rules describe.
  function automatic dec_t model(input logic [N-1:0] x);
    dec_t d;
    longint unsigned a;
    int pos, run, e, nf;
    bit r0;
    d.sign = 0; d.k = 0; d.exp = 0; d.mant = '0;
    d.zero = (x == '0);
    d.inf  = (x == NAR);
    if (d.zero || d.inf) return d;
    d.sign = x[N-1];
    a = d.sign ? ((64'd1 << N) - 64'(x)) : 64'(x);
    pos = N - 2;
    r0  = a[pos];
    run = 0;
    while (pos >= 0 && a[pos] == r0) begin
      run++;
      pos--;
    end
    d.k = r0 ? run - 1 : -run;
    pos--;
    e = 0;
    for (int i = 0; i < ES; i++) begin
      e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    d.exp = e;
    nf = (pos >= 0) ? pos + 1 : 0;
    d.mant = N'((64'd1 << (N - 1)) + ((a & ((64'd1 << nf) - 64'd1)) << (N - 1 - nf)));
    return d;
  endfunction

  function automatic void push_bit(inout longint unsigned bits, inout int len, input bit b);
    if (len < N - 1) begin
      bits = bits * 2 + 64'(b);
      len++;
    end
  endfunction

  // Reference encoder: regime run + terminator, exponent, fraction, truncated to N-1 bits.
  function automatic logic [N-1:0] encode(input dec_t d);
    longint unsigned bits;
    int len, rl;
    logic [N-1:0] r;
    if (d.zero) return '0;
    if (d.inf) return NAR;
    bits = 0;
    len  = 0;
    rl = (d.k >= 0) ? d.k + 1 : -d.k;
    for (int i = 0; i < rl; i++) push_bit(bits, len, d.k >= 0);
    push_bit(bits, len, d.k < 0);
    for (int i = ES - 1; i >= 0; i--) push_bit(bits, len, ((d.exp >> i) & 1) != 0);
    for (int i = N - 2; i >= 0; i--) push_bit(bits, len, d.mant[i]);
    bits = bits << (N - 1 - len);
    r = N'(bits);
    return d.sign ? -r : r;
  endfunction

  function automatic logic [N-1:0] rand_posit();
    logic [N-1:0] sp [6];
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    if ($urandom_range(15) == 0) return sp[$urandom_range(5)];
    return N'($urandom);
  endfunction

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  logic         p_hold = 1'b0;
  logic [43:0]  p_fields;
  always @(negedge clk) begin
    dec_t m, g;
    logic [N-1:0] w;
    if (rst) begin
      sb.delete();
      p_hold = 1'b0;
      spec_model = 0;
    end else begin
      if (p_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_fields", {out_sign, out_k, out_exp, out_mant, out_zero, out_inf}, p_fields);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out_valid 1 expected no pending word");
        end else begin
          w = sb.pop_front();
          m = model(w);
          check("out_sign", out_sign, m.sign);
          check("out_k", $signed(out_k), m.k);
          check("out_exp", out_exp, m.exp);
          check("out_mant", out_mant, m.mant);
          check("out_zero", out_zero, m.zero);
          check("out_inf", out_inf, m.inf);
          g.sign = out_sign; g.k = $signed(out_k); g.exp = out_exp;
          g.mant = out_mant; g.zero = out_zero; g.inf = out_inf;
          check("reencode", encode(g), w);
          if ((m.zero || m.inf) && spec_model < 65535) spec_model++;
        end
      end
      if (in_valid && in_ready) sb.push_back(in_posit);
      p_hold   = out_valid && !out_ready;
      p_fields = {out_sign, out_k, out_exp, out_mant, out_zero, out_inf};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  logic [N-1:0] vecs [7];
  dec_t pm;
  int   n0, sent;
  bit   acc;

  initial begin
    vecs = '{32'h4800_0000, 32'hC000_0000, 32'h7FFF_FFFF, 32'h0000_0001,
             32'h0000_0000, 32'h8000_0000, 32'h4000_0000};
    rst = 1'b1; in_valid = 1'b0; in_posit = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mant", out_mant, 0);
    check("rst_out_k", $signed(out_k), 0);
    check("rst_in_ready", in_ready, 1);
`ifdef POSIT_DEC_STATS_EN
    check("rst_special_cnt", special_cnt, 0);
`endif
    rst = 1'b0;

    pm = model(32'h4800_0000);
    check("pin_4800_k", pm.k, 0);
    check("pin_4800_exp", pm.exp, 1);
    check("pin_4800_mant", pm.mant, 32'h8000_0000);
    pm = model(32'hC000_0000);
    check("pin_C000_sign", pm.sign, 1);
    check("pin_C000_mant", pm.mant, 32'h8000_0000);
    pm = model(32'h7FFF_FFFF);
    check("pin_7FFF_k", pm.k, 30);
    pm = model(32'h0000_0001);
    check("pin_0001_k", pm.k, -30);
    check("pin_0001_exp", pm.exp, 0);
    pm = model(32'h8000_0000);
    check("pin_nar_inf", pm.inf, 1);

    // two-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; in_posit = 32'h4000_0000;
    tick();
    in_valid = 1'b0;
    check("lat_t1_valid", out_valid, 0);
    tick();
    check("lat_t2_valid", out_valid, 1);
    check("lat_sign", out_sign, 0);
    check("lat_k", $signed(out_k), 0);
    check("lat_exp", out_exp, 0);
    check("lat_mant", out_mant, 32'h8000_0000);
    tick();

    foreach (vecs[i]) begin
      in_valid = 1'b1; in_posit = vecs[i];
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();

    // stall with three back-to-back words
    out_ready = 1'b0;
    in_valid = 1'b1; in_posit = 32'h1234_5678;
    check("stall_rdy0", in_ready, 1);
    tick();
    in_posit = 32'hDEAD_BEEF;
    check("stall_rdy1", in_ready, 1);
    tick();
    in_posit = 32'hA5A5_A5A5;
    check("stall_rdy2", in_ready, 0);
    repeat (4) begin
      tick();
      check("stall_hold_rdy", in_ready, 0);
    end
    n0 = n_out;
    out_ready = 1'b1;
    check("rel_v0", out_valid, 1);
    tick();
    in_valid = 1'b0;
    check("rel_v1", out_valid, 1);
    tick();
    check("rel_v2", out_valid, 1);
    tick();
    check("rel_v3", out_valid, 0);
    check("rel_count", n_out - n0, 3);

    // reset with two words in flight
    in_valid = 1'b1; in_posit = 32'h1111_1111;
    tick();
    in_posit = 32'h2222_2222;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    n0 = n_out;
    tick();
    check("rst_mid_edge_valid", out_valid, 0);
    rst = 1'b0;
    repeat (6) tick();
    check("rst_mid_none", n_out - n0, 0);

    // randomized traffic with random back-pressure
    sent = 0;
    for (int c = 0; c < 8000 && sent < 2000; c++) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_posit = rand_posit();
      end
      out_ready = ($urandom_range(9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    check("drain_empty", sb.size(), 0);
    check("random_sent", sent, 2000);

`ifdef POSIT_DEC_STATS_EN
    check("stats_count", special_cnt, spec_model);
    in_valid = 1'b1; in_posit = NAR;
    repeat (70000) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("stats_sat", special_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
